serial_pattern_generator: RTL and testbench

Programmable serial bit-pattern transmitter. Accepts a PAT_W-bit pattern and a repeat count over a valid/ready load port, then drives the pattern MSB-first on a one-bit serial line, one bit per clock, the requested number of times with an optional idle gap between frames. It is the stimulus/transmit end of the serial sequence-detection path: its `x` output drives a sequence detector's `x` input, with default parameters producing 4-bit frames such as 1010.

---
 rtl/serial_pattern_generator_pkg.sv | 19 +
 rtl/piso_shift_reg.sv | 39 +++
 rtl/serial_pattern_generator.sv | 152 +++++++++++++++
 tb/tb_serial_pattern_generator.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/serial_pattern_generator_pkg.sv
// Shared types and defaults for the serial pattern generator.
//   state_e        : FSM state encoding (IDLE / SHIFT / GAP), 2 bits
//   *_DEF          : default parameter values for the top level
//   TEST_FRAME     : default 4-bit frame used to exercise a sequence detector
package serial_pattern_generator_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    GAP   = 2'd2
  } state_e;

  localparam int PAT_W_DEF      = 4;
  localparam int CNT_W_DEF      = 4;
  localparam int GAP_CYCLES_DEF = 0;

  localparam logic [3:0] TEST_FRAME = 4'b1010;

endpackage

// File: rtl/piso_shift_reg.sv
// Parallel-in / serial-out shift register with a pattern copy.
//   clk, rst        : clock, synchronous active-low reset
//   load, shift     : load only  -> capture din into copy and shift register
//                     load+shift -> reload shift register from the copy
//                     shift only -> shift left, zero fill
//   din[W-1:0]      : parallel pattern
//   msb_out         : current MSB of the shift register (flop output)
module piso_shift_reg #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic         shift,
  input  logic [W-1:0] din,
  output logic         msb_out
);

  logic [W-1:0] copy_q;
  logic [W-1:0] sr_q;

  always_ff @(posedge clk) begin
    if (!rst) begin
      copy_q <= '0;
      sr_q   <= '0;
    end else if (load && !shift) begin
      copy_q <= din;
      sr_q   <= din;
    end else if (load && shift) begin
      // frame boundary: restart the same pattern
      sr_q   <= copy_q;
    end else if (shift) begin
      sr_q   <= {sr_q[W-2:0], 1'b0};
    end
  end

  assign msb_out = sr_q[W-1];

endmodule

// File: rtl/serial_pattern_generator.sv
// Serial bit-pattern transmitter. Sends a loaded PAT_W-bit pattern MSB-first,
// load_repeat+1 times, with GAP_CYCLES idle cycles between frames.
//   clk, rst                 : clock, synchronous active-low reset
//   load_valid / load_ready  : load handshake (load_ready is combinational)
//   load_pattern, load_repeat: pattern and repeat count (N -> N+1 frames)
//   abort                    : cancel current transfer, no done pulse
//   x, x_valid, frame_start  : serial data stream
//   busy                     : in SHIFT or GAP
//   done                     : one-cycle pulse after the last bit
module serial_pattern_generator
  import serial_pattern_generator_pkg::*;
#(
  parameter int PAT_W      = PAT_W_DEF,
  parameter int CNT_W      = CNT_W_DEF,
  parameter int GAP_CYCLES = GAP_CYCLES_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_valid,
  output logic             load_ready,
  input  logic [PAT_W-1:0] load_pattern,
  input  logic [CNT_W-1:0] load_repeat,
  input  logic             abort,
  output logic             x,
  output logic             x_valid,
  output logic             frame_start,
  output logic             busy,
  output logic             done
);

  localparam int BW = $clog2(PAT_W);
  // keep a 1-bit counter when there is no gap so the logic still elaborates
  localparam int GW = (GAP_CYCLES > 0) ? $clog2(GAP_CYCLES + 1) : 1;
  localparam logic [BW-1:0] BLAST = BW'(PAT_W - 1);
  localparam logic [GW-1:0] GLAST = GW'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

  state_e           state, state_n;
  logic [BW-1:0]    bcnt, bcnt_n;
  logic [CNT_W-1:0] fcnt, fcnt_n;
  logic [GW-1:0]    gcnt, gcnt_n;
  logic             pload, pshift;
  logic             xv_q, fs_q, busy_q, done_q;
  logic             xv_n, fs_n, busy_n, done_n;
  logic             msb;
  logic             accept;

  assign load_ready = rst && (state == IDLE) && !abort;
  assign accept     = load_valid && load_ready;

  piso_shift_reg #(.W(PAT_W)) u_piso (
    .clk     (clk),
    .rst     (rst),
    .load    (pload),
    .shift   (pshift),
    .din     (load_pattern),
    .msb_out (msb)
  );

  // state, counters and output registers
  always_ff @(posedge clk) begin
    if (!rst) begin
      state  <= IDLE;
      bcnt   <= '0;
      fcnt   <= '0;
      gcnt   <= '0;
      xv_q   <= 1'b0;
      fs_q   <= 1'b0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      state  <= state_n;
      bcnt   <= bcnt_n;
      fcnt   <= fcnt_n;
      gcnt   <= gcnt_n;
      xv_q   <= xv_n;
      fs_q   <= fs_n;
      busy_q <= busy_n;
      done_q <= done_n;
    end
  end

  // next state, counters, shift-register controls
  always_comb begin
    state_n = state;
    bcnt_n  = bcnt;
    fcnt_n  = fcnt;
    gcnt_n  = gcnt;
    pload   = 1'b0;
    pshift  = 1'b0;
    unique case (state)
      IDLE: begin
        if (accept) begin
          state_n = SHIFT;
          bcnt_n  = '0;
          fcnt_n  = load_repeat;
          pload   = 1'b1;
        end
      end
      SHIFT: begin
        if (bcnt == BLAST) begin
          if (fcnt == '0) begin
            state_n = IDLE;
          end else begin
            fcnt_n  = fcnt - 1'b1;
            bcnt_n  = '0;
            gcnt_n  = '0;
            pload   = 1'b1;
            pshift  = 1'b1;
            state_n = (GAP_CYCLES == 0) ? SHIFT : GAP;
          end
        end else begin
          bcnt_n = bcnt + 1'b1;
          pshift = 1'b1;
        end
      end
      GAP: begin
        if (gcnt == GLAST) begin
          state_n = SHIFT;
          bcnt_n  = '0;
        end else begin
          gcnt_n = gcnt + 1'b1;
        end
      end
      default: state_n = IDLE;
    endcase
    // abort overrides everything, including the final-bit transition
    if (abort && state != IDLE) begin
      state_n = IDLE;
      bcnt_n  = '0;
      fcnt_n  = '0;
      gcnt_n  = '0;
      pload   = 1'b0;
      pshift  = 1'b0;
    end
  end

  // next values of the registered outputs
  always_comb begin
    xv_n   = (state_n == SHIFT);
    fs_n   = (state_n == SHIFT) && (bcnt_n == '0);
    busy_n = (state_n != IDLE);
    done_n = (state == SHIFT) && (bcnt == BLAST) && (fcnt == '0) && !abort;
  end

  // msb is itself a flop; gating with the x_valid flop keeps x at 0 outside SHIFT
  assign x           = xv_q & msb;
  assign x_valid     = xv_q;
  assign frame_start = fs_q;
  assign busy        = busy_q;
  assign done        = done_q;

endmodule

// File: tb/tb_serial_pattern_generator.sv
module tb_serial_pattern_generator;
  import serial_pattern_generator_pkg::*;

  localparam int W  = 4;
  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          lv0 = 1'b0, lv2 = 1'b0;
  logic [W-1:0]  pat = '0;
  logic [CW-1:0] rep = '0;
  logic          abort = 1'b0;
  logic          rdy0, x0, xv0, fs0, busy0, done0;
  logic          rdy2, x2, xv2, fs2, busy2, done2;

  always #5 clk = ~clk;

  serial_pattern_generator #(.PAT_W(W), .CNT_W(CW), .GAP_CYCLES(0)) dut0 (
    .clk(clk), .rst(rst), .load_valid(lv0), .load_ready(rdy0),
    .load_pattern(pat), .load_repeat(rep), .abort(abort),
    .x(x0), .x_valid(xv0), .frame_start(fs0), .busy(busy0), .done(done0));

  serial_pattern_generator #(.PAT_W(W), .CNT_W(CW), .GAP_CYCLES(2)) dut2 (
    .clk(clk), .rst(rst), .load_valid(lv2), .load_ready(rdy2),
    .load_pattern(pat), .load_repeat(rep), .abort(abort),
    .x(x2), .x_valid(xv2), .frame_start(fs2), .busy(busy2), .done(done2));

  typedef struct packed {
    logic ready;
    logic busy;
    logic done;
    logic fs;
    logic xv;
    logic x;
  } rec_t;

  rec_t q[$];
  int   n_cmp = 0;
  int   n_err = 0;

  function automatic rec_t mk(input logic r, b, d, f, v, xx);
    rec_t t;
    t = {r, b, d, f, v, xx};
    return t;
  endfunction

  // expected per-cycle outputs of one transfer, starting the cycle after accept
  function automatic void push_seq(input logic [W-1:0] p, input int n, input int gap,
                                   input bit idle);
    for (int k = 0; k <= n; k++) begin
      for (int b = 0; b < W; b++) q.push_back(mk(0, 1, 0, b == 0, 1, p[W-1-b]));
      if (k < n) for (int g = 0; g < gap; g++) q.push_back(mk(0, 1, 0, 0, 0, 0));
    end
    q.push_back(mk(1, 0, 1, 0, 0, 0));
    if (idle) q.push_back(mk(1, 0, 0, 0, 0, 0));
  endfunction

  function automatic rec_t obs(input bit sel);
    rec_t t;
    t = sel ? {rdy2, busy2, done2, fs2, xv2, x2} : {rdy0, busy0, done0, fs0, xv0, x0};
    return t;
  endfunction

  task automatic test_reset();
    rec_t o;
    rst = 1'b0;
    repeat (2) @(negedge clk);
    for (int s = 0; s < 2; s++) begin
      o = obs(s[0]);
      n_cmp++;
      if (o !== '0) begin
        n_err++;
        $display("FAIL reset dut%0d got=%b exp=%b", s * 2, o, 6'b0);
      end
    end
    rst = 1'b1;
    #1;
    n_cmp++;
    if ({rdy0, rdy2} !== 2'b11) begin
      n_err++;
      $display("FAIL reset_release_ready got=%b exp=11", {rdy0, rdy2});
    end
  endtask

  task automatic test_single();
    rec_t e, o;
    @(negedge clk);
    pat = TEST_FRAME; rep = 0; lv0 = 1'b1;
    push_seq(TEST_FRAME, 0, 0, 1);
    for (int i = 0; q.size() > 0 && i < 200; i++) begin
      @(negedge clk);
      e = q.pop_front();
      if (!rst || abort) e.ready = 1'b0;
      o = obs(1'b0);
      n_cmp++;
      if (o !== e) begin
        n_err++;
        $display("FAIL single cyc%0d got=%b exp=%b", i, o, e);
      end
      if (i == 0) lv0 = 1'b0;
    end
  endtask

  task automatic test_repeat();
    rec_t e, o;
    @(negedge clk);
    pat = 4'b1010; rep = 2; lv0 = 1'b1;
    push_seq(4'b1010, 2, 0, 1);
    for (int i = 0; q.size() > 0 && i < 200; i++) begin
      @(negedge clk);
      e = q.pop_front();
      if (!rst || abort) e.ready = 1'b0;
      o = obs(1'b0);
      n_cmp++;
      if (o !== e) begin
        n_err++;
        $display("FAIL repeat cyc%0d got=%b exp=%b", i, o, e);
      end
      if (i == 0) lv0 = 1'b0;
    end
  endtask

  task automatic test_gap();
    rec_t e, o;
    @(negedge clk);
    pat = 4'b1100; rep = 1; lv2 = 1'b1;
    push_seq(4'b1100, 1, 2, 1);
    for (int i = 0; q.size() > 0 && i < 200; i++) begin
      @(negedge clk);
      e = q.pop_front();
      if (!rst || abort) e.ready = 1'b0;
      o = obs(1'b1);
      n_cmp++;
      if (o !== e) begin
        n_err++;
        $display("FAIL gap cyc%0d got=%b exp=%b", i, o, e);
      end
      if (i == 0) lv2 = 1'b0;
    end
  endtask

  task automatic test_abort();
    rec_t e, o;
    @(negedge clk);
    pat = 4'b1010; rep = 3; lv0 = 1'b1;
    q.push_back(mk(0, 1, 0, 1, 1, 1));
    q.push_back(mk(0, 1, 0, 0, 1, 0));
    q.push_back(mk(0, 1, 0, 0, 1, 1));
    q.push_back(mk(1, 0, 0, 0, 0, 0));
    push_seq(4'b1010, 0, 0, 1);
    q.push_back(mk(1, 0, 0, 0, 0, 0));
    for (int i = 0; q.size() > 0 && i < 200; i++) begin
      @(negedge clk);
      e = q.pop_front();
      if (!rst || abort) e.ready = 1'b0;
      o = obs(1'b0);
      n_cmp++;
      if (o !== e) begin
        n_err++;
        $display("FAIL abort cyc%0d got=%b exp=%b", i, o, e);
      end
      if (i == 0) lv0 = 1'b0;
      if (i == 2) abort = 1'b1;
      if (i == 3) begin
        abort = 1'b0; rep = 0; lv0 = 1'b1;
        #1;
        n_cmp++;
        if (rdy0 !== 1'b1) begin
          n_err++;
          $display("FAIL abort_reload_ready got=%b exp=1", rdy0);
        end
      end
      if (i == 4) lv0 = 1'b0;
    end
  endtask

  task automatic test_reset_mid();
    rec_t e, o;
    @(negedge clk);
    pat = 4'b1010; rep = 0; lv0 = 1'b1;
    q.push_back(mk(0, 1, 0, 1, 1, 1));
    q.push_back(mk(0, 1, 0, 0, 1, 0));
    repeat (2) q.push_back(mk(0, 0, 0, 0, 0, 0));
    repeat (3) q.push_back(mk(1, 0, 0, 0, 0, 0));
    for (int i = 0; q.size() > 0 && i < 200; i++) begin
      @(negedge clk);
      e = q.pop_front();
      if (!rst || abort) e.ready = 1'b0;
      o = obs(1'b0);
      n_cmp++;
      if (o !== e) begin
        n_err++;
        $display("FAIL reset_mid cyc%0d got=%b exp=%b", i, o, e);
      end
      if (i == 0) lv0 = 1'b0;
      if (i == 1) begin
        rst = 1'b0;
        #1;
        n_cmp++;
        if (rdy0 !== 1'b0) begin
          n_err++;
          $display("FAIL reset_mid_ready got=%b exp=0", rdy0);
        end
      end
      if (i == 3) rst = 1'b1;
    end
  endtask

  // load_valid held high: loads land only in IDLE/done cycles, never with abort
  task automatic test_back_to_back();
    rec_t e, o;
    @(negedge clk);
    pat = 4'b1010; rep = 0; lv0 = 1'b1;
    push_seq(4'b1010, 0, 0, 0);
    push_seq(4'b1001, 0, 0, 0);
    q.push_back(mk(1, 0, 0, 0, 0, 0));
    push_seq(4'b0110, 0, 0, 1);
    for (int i = 0; q.size() > 0 && i < 200; i++) begin
      @(negedge clk);
      e = q.pop_front();
      if (!rst || abort) e.ready = 1'b0;
      o = obs(1'b0);
      n_cmp++;
      if (o !== e) begin
        n_err++;
        $display("FAIL back_to_back cyc%0d got=%b exp=%b", i, o, e);
      end
      if (i == 4) pat = 4'b1001;
      if (i == 9) begin
        abort = 1'b1;
        #1;
        n_cmp++;
        if (rdy0 !== 1'b0) begin
          n_err++;
          $display("FAIL abort_blocks_load got=%b exp=0", rdy0);
        end
      end
      if (i == 10) begin
        abort = 1'b0; pat = 4'b0110;
        #1;
        n_cmp++;
        if (rdy0 !== 1'b1) begin
          n_err++;
          $display("FAIL ready_after_abort_low got=%b exp=1", rdy0);
        end
      end
      if (i == 11) lv0 = 1'b0;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_single();
    test_repeat();
    test_gap();
    test_abort();
    test_reset_mid();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
